lookup_arbiter: RTL

LOOKUP_ARBITER -- requirements
Module: lookup_arbiter

---
 rtl/lookup_arbiter.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lookup_arbiter.sv
// -----------------------------------------------------------------------------
// lookup_arbiter
//
// Round-robin arbiter that shares one single-port lookup resource (a ROM/RAM
// with one cycle of read latency) between N requesters. Only one transaction
// is in flight at a time. Each transaction is accepted in IDLE, issued to the
// lookup in ISSUE, captured in WAIT, and presented in RESP until the response
// sink takes it.
//
// Ports
//   i_clk        : sole clock, rising edge
//   i_rst        : synchronous, active-high reset
//   i_req_valid  : [N]      per-requester lookup request
//   i_req_index  : [N*AW]   per-requester index, requester k at [k*AW +: AW]
//   o_req_ready  : [N]      one-hot accept, only ever asserted in IDLE
//   o_lut_en     : read strobe to the shared lookup resource
//   o_lut_addr   : [AW]     read address to the shared lookup resource
//   i_lut_data   : [DW]     read data, valid one cycle after o_lut_en
//   o_rsp_valid  : response valid
//   o_rsp_data   : [DW]     response data
//   o_rsp_id     : [$clog2(N)] requester that owns the response
//   o_rsp_err    : out-of-range index flag
//   i_rsp_ready  : response sink ready
//
// Configuration
//   LOOKUP_ARBITER_RANGE_CHECK_EN : when defined, an index >= DEPTH skips the
//   lookup entirely and is answered one cycle after accept with data 0 and
//   o_rsp_err = 1. When undefined, every index goes to the lookup unchanged
//   and o_rsp_err is tied to 0.
// -----------------------------------------------------------------------------
module lookup_arbiter #(
    parameter int N     = 4,
    parameter int AW    = 4,
    parameter int DW    = 32,
    parameter int DEPTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N-1:0]         i_req_valid,
    input  logic [N*AW-1:0]      i_req_index,
    output logic [N-1:0]         o_req_ready,
    output logic                 o_lut_en,
    output logic [AW-1:0]        o_lut_addr,
    input  logic [DW-1:0]        i_lut_data,
    output logic                 o_rsp_valid,
    output logic [DW-1:0]        o_rsp_data,
    output logic [$clog2(N)-1:0] o_rsp_id,
    output logic                 o_rsp_err,
    input  logic                 i_rsp_ready
);

    localparam int IW = $clog2(N);

    // Reject parameter sets the arbitration and range logic are not built for.
    if (N < 2 || N > 8 || DEPTH < 1 || DEPTH > (1 << AW)) begin : g_param_check
        $error("lookup_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t         state_q;
    state_t         state_d;

    logic [IW-1:0]  ptr_q;
    logic [IW-1:0]  id_q;
    logic [AW-1:0]  index_q;
    logic [DW-1:0]  rsp_data_q;

    logic           grant_valid;
    logic [IW-1:0]  grant_id;
    logic [AW-1:0]  grant_index;

    logic [IW:0]    ptr_inc;
    logic [IW-1:0]  ptr_next;

`ifdef LOOKUP_ARBITER_RANGE_CHECK_EN
    logic           err_q;
    logic           grant_oor;
`endif

    // -------------------------------------------------------------------------
    // Round-robin pick: scan the requesters starting at ptr and wrapping at N.
    // The candidate is computed one bit wider than the id so that ptr + i can
    // be wrapped correctly even when N is not a power of two.
    // -------------------------------------------------------------------------
    always_comb begin
        logic [IW:0] cand;
        cand        = '0;
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(i);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!grant_valid && i_req_valid[cand[IW-1:0]]) begin
                grant_valid = 1'b1;
                grant_id    = cand[IW-1:0];
            end
        end
    end

    // Select the index belonging to the winning requester.
    always_comb begin
        grant_index = '0;
        for (int k = 0; k < N; k++) begin
            if (grant_id == IW'(k)) begin
                grant_index = i_req_index[k*AW +: AW];
            end
        end
    end

`ifdef LOOKUP_ARBITER_RANGE_CHECK_EN
    // Indices at or beyond DEPTH are never sent to the lookup resource.
    assign grant_oor = (32'(grant_index) >= 32'(DEPTH));
`endif

    // After a completed response the pointer moves just past its owner, so
    // the owner becomes the lowest-priority requester for the next pick.
    assign ptr_inc  = {1'b0, id_q} + (IW+1)'(1);
    assign ptr_next = (ptr_inc == (IW+1)'(N)) ? '0 : ptr_inc[IW-1:0];

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
`ifdef LOOKUP_ARBITER_RANGE_CHECK_EN
                    state_d = grant_oor ? RESP : ISSUE;
`else
                    state_d = ISSUE;
`endif
                end
            end
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = RESP;
            RESP: begin
                if (i_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM outputs. o_req_ready is combinational so that the accept happens in
    // the same cycle the request is seen; it is masked during reset so nothing
    // is handshaken while the block is being cleared.
    // -------------------------------------------------------------------------
    always_comb begin
        o_req_ready = '0;
        o_lut_en    = 1'b0;
        o_lut_addr  = '0;
        o_rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid && !i_rst) begin
                    for (int k = 0; k < N; k++) begin
                        o_req_ready[k] = (grant_id == IW'(k));
                    end
                end
            end
            ISSUE: begin
                o_lut_en   = 1'b1;
                o_lut_addr = index_q;
            end
            RESP: begin
                o_rsp_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Transaction datapath: latch owner and index on accept, capture lookup
    // data in WAIT, and advance the round-robin pointer on the response
    // handshake. Reset clears everything, discarding any transaction in flight.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q      <= '0;
            id_q       <= '0;
            index_q    <= '0;
            rsp_data_q <= '0;
`ifdef LOOKUP_ARBITER_RANGE_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        id_q    <= grant_id;
                        index_q <= grant_index;
`ifdef LOOKUP_ARBITER_RANGE_CHECK_EN
                        err_q   <= grant_oor;
                        if (grant_oor) begin
                            rsp_data_q <= '0;
                        end
`endif
                    end
                end
                WAIT: begin
                    rsp_data_q <= i_lut_data;
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        ptr_q <= ptr_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_rsp_data = rsp_data_q;
    assign o_rsp_id   = id_q;

`ifdef LOOKUP_ARBITER_RANGE_CHECK_EN
    assign o_rsp_err = err_q;
`else
    assign o_rsp_err = 1'b0;
`endif

endmodule
